// File: rtl/dsi_lane_stream_arbiter_if.sv
// Byte-stream FIFO read port: head byte, empty flag, last-byte qualifier, pop strobe.
// Latency: none, this is a plain bundle of wires.
// Backpressure: the reader pops with read; the provider holds data until it is popped.
interface dsi_lane_stream_arbiter_if;
  logic [7:0] data;
  logic       empty;
  logic       last;
  logic       read;

  // Provider side: the FIFO that owns the bytes.
  modport master (
    output data,
    output empty,
    output last,
    input  read
  );

  // Consumer side: the block that pops the bytes.
  modport slave (
    input  data,
    input  empty,
    input  last,
    output read
  );
endinterface

// File: rtl/dsi_lane_stream_arbiter.sv
// Shares one lane byte-stream between the HS packet source and the LP command source.
// Latency: a grant takes one cycle from request; bytes then pass through combinationally.
// Backpressure: out.read pops the granted source only while it is non-empty.
module dsi_lane_stream_arbiter #(
  parameter bit LP_PRIORITY = 1'b1,
  parameter int GAP_CYCLES  = 4,
  parameter int CNT_W       = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  dsi_lane_stream_arbiter_if.slave  hs,
  dsi_lane_stream_arbiter_if.slave  lp,
  dsi_lane_stream_arbiter_if.master out,
  output logic                    out_mode_lp,
  output logic [1:0]              grant,
  output logic                    pkt_done,
  output logic                    underrun,
  output logic [CNT_W-1:0]        pkt_bytes
);

  typedef enum logic [1:0] {
    IDLE,
    SERVE_HS,
    SERVE_LP,
    GAP
  } state_t;

  // The gap counter is reloaded with GAP_CYCLES-1 so that the GAP state lasts
  // exactly GAP_CYCLES cycles, counting down to zero inclusive.
  localparam logic [7:0] GAP_INIT = 8'(GAP_CYCLES - 1);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  logic             last_lp;      // last completed grant: 1 = LP, 0 = HS
  logic [CNT_W-1:0] byte_cnt;     // bytes popped so far in the current packet
  logic [7:0]       gap_cnt;
  logic             in_underrun;  // granted source is currently in an empty episode

  logic             hs_req;
  logic             lp_req;
  logic             pick_lp;
  logic             src_empty;
  logic             src_last;
  logic             src_read;
  logic [CNT_W-1:0] cnt_next;

  // Requests and arbitration decision, only used while in IDLE.
  always_comb begin
    hs_req  = !hs.empty;
    lp_req  = !lp.empty;
    // With LP priority, LP wins any tie; otherwise the tie goes to the source
    // that did not carry the previous packet.
    pick_lp = lp_req & (!hs_req | LP_PRIORITY | !last_lp);
  end

  // Data path: steer the granted source to the lane port, and route the pop back.
  // Reads are held off while rst is high so that an abandoned packet leaves its
  // remaining bytes, including the one on the head, inside the source FIFO.
  always_comb begin
    out.data  = 8'h00;
    out.empty = 1'b1;
    out.last  = 1'b0;
    hs.read   = 1'b0;
    lp.read   = 1'b0;
    case (state)
      SERVE_HS: begin
        out.data  = hs.data;
        out.empty = hs.empty;
        out.last  = hs.last;
        hs.read   = out.read & !hs.empty & !rst;
      end
      SERVE_LP: begin
        out.data  = lp.data;
        out.empty = lp.empty;
        out.last  = lp.last;
        lp.read   = out.read & !lp.empty & !rst;
      end
      default: begin
      end
    endcase
  end

  // Status of the granted source and the saturating next byte count.
  always_comb begin
    src_empty = (state == SERVE_LP) ? lp.empty : hs.empty;
    src_last  = (state == SERVE_LP) ? lp.last  : hs.last;
    src_read  = hs.read | lp.read;
    cnt_next  = (&byte_cnt) ? byte_cnt : byte_cnt + CNT_ONE;
  end

  // Control FSM with registered grant, lane mode, pulses and packet length.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= 2'b00;
      out_mode_lp <= 1'b0;
      pkt_done    <= 1'b0;
      underrun    <= 1'b0;
      pkt_bytes   <= '0;
      last_lp     <= 1'b0;
      byte_cnt    <= '0;
      gap_cnt     <= 8'd0;
      in_underrun <= 1'b0;
    end else begin
      pkt_done <= 1'b0;
      underrun <= 1'b0;
      case (state)
        IDLE: begin
          in_underrun <= 1'b0;
          if (hs_req || lp_req) begin
            if (pick_lp) begin
              state       <= SERVE_LP;
              grant       <= 2'b10;
              out_mode_lp <= 1'b1;
            end else begin
              state       <= SERVE_HS;
              grant       <= 2'b01;
              out_mode_lp <= 1'b0;
            end
          end
        end

        SERVE_HS, SERVE_LP: begin
          if (src_read) begin
            if (src_last) begin
              // Packet boundary: release the lane and start the forced gap.
              state     <= GAP;
              grant     <= 2'b00;
              last_lp   <= (state == SERVE_LP);
              pkt_done  <= 1'b1;
              pkt_bytes <= cnt_next;
              byte_cnt  <= '0;
              gap_cnt   <= GAP_INIT;
            end else begin
              byte_cnt  <= cnt_next;
            end
          end
          // A source running dry after its first byte is an underrun; flag it
          // once per episode and keep the grant until the packet finishes.
          if (src_empty && (byte_cnt != '0)) begin
            underrun    <= !in_underrun;
            in_underrun <= 1'b1;
          end else begin
            in_underrun <= 1'b0;
          end
        end

        GAP: begin
          // Lane mode keeps the last served value until the gap has elapsed.
          if (gap_cnt == 8'd0) begin
            state       <= IDLE;
            out_mode_lp <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dsi_lane_stream_arbiter.sv
// Bench for the lane stream arbiter: source FIFO models, byte and packet scoreboards.
// Latency: checks grant one cycle after request and a GAP_CYCLES+1 empty gap.
// Backpressure: the bridge side pops whenever out_read is high and out_empty is low.
module tb_dsi_lane_stream_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic sel;       // 0 = LP-priority instance active, 1 = round-robin instance active
  logic out_read;

  dsi_lane_stream_arbiter_if hs0 ();
  dsi_lane_stream_arbiter_if lp0 ();
  dsi_lane_stream_arbiter_if out0 ();
  dsi_lane_stream_arbiter_if hs1 ();
  dsi_lane_stream_arbiter_if lp1 ();
  dsi_lane_stream_arbiter_if out1 ();

  logic        mode0, mode1, done0, done1, ur0, ur1;
  logic [1:0]  grant0, grant1;
  logic [15:0] bytes0, bytes1;

  dsi_lane_stream_arbiter #(.LP_PRIORITY(1'b1), .GAP_CYCLES(4), .CNT_W(16)) dut_pri (
    .clk(clk), .rst(rst | sel), .hs(hs0), .lp(lp0), .out(out0),
    .out_mode_lp(mode0), .grant(grant0), .pkt_done(done0), .underrun(ur0), .pkt_bytes(bytes0)
  );

  dsi_lane_stream_arbiter #(.LP_PRIORITY(1'b0), .GAP_CYCLES(4), .CNT_W(16)) dut_rr (
    .clk(clk), .rst(rst | ~sel), .hs(hs1), .lp(lp1), .out(out1),
    .out_mode_lp(mode1), .grant(grant1), .pkt_done(done1), .underrun(ur1), .pkt_bytes(bytes1)
  );

  wire [7:0]  o_data    = sel ? out1.data  : out0.data;
  wire        o_empty   = sel ? out1.empty : out0.empty;
  wire        o_mode    = sel ? mode1      : mode0;
  wire [1:0]  o_grant   = sel ? grant1     : grant0;
  wire        o_done    = sel ? done1      : done0;
  wire        o_ur      = sel ? ur1        : ur0;
  wire [15:0] o_bytes   = sel ? bytes1     : bytes0;
  wire        o_hs_read = sel ? hs1.read   : hs0.read;
  wire        o_lp_read = sel ? lp1.read   : lp0.read;

  logic [8:0] hs_q[$];   // {last, data}
  logic [8:0] lp_q[$];
  logic [9:0] exp_q[$];  // {last, mode_lp, data} in expected lane order
  int         pkt_q[$];  // expected pkt_bytes per completed packet

  int tests_run;
  int tests_failed;
  int pops;
  int ur_cnt;
  int empty_run;
  bit gap_armed;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic load(input bit is_lp, input logic [7:0] base, input int n, input bit with_last);
    for (int i = 0; i < n; i++) begin
      logic [8:0] e;
      e = {with_last && (i == n - 1), 8'(base + i)};
      if (is_lp) lp_q.push_back(e);
      else       hs_q.push_back(e);
    end
  endtask

  task automatic expect_bytes(input bit is_lp, input logic [7:0] base, input int n, input int pkt_len);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({(i == n - 1), is_lp, 8'(base + i)});
    end
    if (pkt_len != 0) pkt_q.push_back(pkt_len);
  endtask

  task automatic drive();
    logic [8:0] h;
    logic [8:0] l;
    h = (hs_q.size() > 0) ? hs_q[0] : 9'h000;
    l = (lp_q.size() > 0) ? lp_q[0] : 9'h000;
    hs0.data = h[7:0]; hs0.last = h[8]; hs0.empty = (hs_q.size() == 0);
    hs1.data = h[7:0]; hs1.last = h[8]; hs1.empty = (hs_q.size() == 0);
    lp0.data = l[7:0]; lp0.last = l[8]; lp0.empty = (lp_q.size() == 0);
    lp1.data = l[7:0]; lp1.last = l[8]; lp1.empty = (lp_q.size() == 0);
    out0.read = out_read & ~sel;
    out1.read = out_read & sel;
  endtask

  task automatic settle();
    drive();
    #1;
  endtask

  // One clock: drive inputs, observe the settled outputs, take the edge, apply pops.
  task automatic cycle();
    bit pop_h;
    bit pop_l;
    logic [9:0] e;
    pop_h = 1'b0;
    pop_l = 1'b0;
    settle();
    if (rst) gap_armed = 1'b0;
    if (gap_armed) begin
      if (o_empty) empty_run++;
      else begin
        chk("gap_len", empty_run, 5);
        gap_armed = 1'b0;
      end
    end
    if (o_hs_read && hs_q.size() == 0) chk("hs_read_empty", o_hs_read, 0);
    if (o_lp_read && lp_q.size() == 0) chk("lp_read_empty", o_lp_read, 0);
    if (o_hs_read && o_lp_read) chk("both_read", o_lp_read, 0);
    if (out_read && !o_empty && !rst) chk("read_fwd", o_hs_read | o_lp_read, 1);
    if ((o_hs_read && hs_q.size() > 0) || (o_lp_read && lp_q.size() > 0)) begin
      pop_h = o_hs_read;
      pop_l = o_lp_read;
      pops++;
      if (exp_q.size() == 0) chk("extra_byte", exp_q.size(), 1);
      else begin
        e = exp_q.pop_front();
        chk("data", o_data, e[7:0]);
        chk("mode", o_mode, e[8]);
        chk("grant", o_grant, e[8] ? 2 : 1);
        chk("src_read", o_lp_read, e[8]);
        if (e[9]) begin
          empty_run = 0;
          gap_armed = 1'b1;
        end
      end
    end
    if (o_done) begin
      if (pkt_q.size() == 0) chk("extra_pkt_done", pkt_q.size(), 1);
      else chk("pkt_bytes", o_bytes, pkt_q.pop_front());
    end
    if (o_ur) ur_cnt++;
    @(posedge clk);
    if (pop_h) void'(hs_q.pop_front());
    if (pop_l) void'(lp_q.pop_front());
    @(negedge clk);
  endtask

  task automatic run_until_drained(input int budget, input string tag);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || pkt_q.size() > 0) && n < budget) begin
      cycle();
      n++;
    end
    chk({tag, "_drained"}, exp_q.size() + pkt_q.size(), 0);
    repeat (2) cycle();
    gap_armed = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run", tests_run);
    $fatal(1);
  end

  initial begin
    int start;
    int n;
    tests_run    = 0;
    tests_failed = 0;
    pops         = 0;
    ur_cnt       = 0;
    empty_run    = 0;
    gap_armed    = 1'b0;
    rst          = 1'b1;
    sel          = 1'b0;
    out_read     = 1'b0;
    drive();
    @(negedge clk);

    // Reset with both sources pending; LP priority, then two HS packets back to back.
    load(1'b1, 8'hA1, 3, 1'b1);
    load(1'b0, 8'h11, 5, 1'b1);
    load(1'b0, 8'h21, 2, 1'b1);
    expect_bytes(1'b1, 8'hA1, 3, 3);
    expect_bytes(1'b0, 8'h11, 5, 5);
    expect_bytes(1'b0, 8'h21, 2, 2);
    repeat (2) begin
      cycle();
      settle();
      chk("rst_empty", o_empty, 1);
      chk("rst_grant", o_grant, 0);
      chk("rst_hs_read", o_hs_read, 0);
      chk("rst_lp_read", o_lp_read, 0);
    end
    rst = 1'b0;
    settle();
    chk("idle_grant", o_grant, 0);
    chk("idle_data", o_data, 0);
    chk("idle_mode", o_mode, 0);
    chk("rst_pkt_bytes", o_bytes, 0);
    cycle();
    settle();
    chk("first_grant", o_grant, 2);
    out_read = 1'b1;
    run_until_drained(200, "prio");

    // Round-robin instance: continuous 2-byte packets on both, LP goes first.
    out_read = 1'b0;
    sel      = 1'b1;
    rst      = 1'b1;
    for (int k = 0; k < 3; k++) begin
      load(1'b0, 8'(8'h31 + 2 * k), 2, 1'b1);
      load(1'b1, 8'(8'hB1 + 2 * k), 2, 1'b1);
    end
    for (int k = 0; k < 3; k++) begin
      expect_bytes(1'b1, 8'(8'hB1 + 2 * k), 2, 2);
      expect_bytes(1'b0, 8'(8'h31 + 2 * k), 2, 2);
    end
    repeat (2) cycle();
    rst      = 1'b0;
    out_read = 1'b1;
    run_until_drained(300, "rr");

    // HS runs dry after 2 of 4 bytes while LP becomes ready.
    out_read = 1'b0;
    sel      = 1'b0;
    rst      = 1'b1;
    repeat (2) cycle();
    rst      = 1'b0;
    ur_cnt   = 0;
    out_read = 1'b1;
    load(1'b0, 8'h41, 2, 1'b0);
    expect_bytes(1'b0, 8'h41, 4, 4);
    repeat (8) cycle();
    load(1'b1, 8'hC1, 3, 1'b1);
    expect_bytes(1'b1, 8'hC1, 3, 3);
    repeat (4) begin
      cycle();
      settle();
      chk("ur_grant_hold", o_grant, 1);
      chk("ur_lp_blocked", o_lp_read, 0);
    end
    chk("underrun_once", ur_cnt, 1);
    load(1'b0, 8'h43, 2, 1'b1);
    run_until_drained(200, "underrun");
    chk("underrun_total", ur_cnt, 1);

    // Reset in the middle of a 6-byte LP packet; the rest is served after release.
    load(1'b1, 8'h61, 6, 1'b1);
    expect_bytes(1'b1, 8'h61, 6, 4);
    start = pops;
    n     = 0;
    while (pops - start < 2 && n < 30) begin
      cycle();
      n++;
    end
    chk("mid_pkt_pops", pops - start, 2);
    rst = 1'b1;
    cycle();
    settle();
    chk("mid_rst_lp_read", o_lp_read, 0);
    chk("mid_rst_empty", o_empty, 1);
    chk("mid_rst_grant", o_grant, 0);
    rst = 1'b0;
    run_until_drained(200, "mid_rst");
    chk("mid_rst_lp_left", lp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
